// File: rtl/x2050roseq.sv
// Control-store address sequencer: forms the next ROS address from the microword
// field and branch conditions, with call stack, prioritised trap vectors and address history.
module x2050roseq #(
  parameter int AW     = 13,
  parameter int NCOND  = 64,
  parameter int SDEPTH = 4,
  parameter int HDEPTH = 4,
  parameter int NTRAP  = 4,
  parameter logic [AW-1:0] TRAP_BASE = 13'h040,
  localparam int CW = $clog2(NCOND)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_ros_advance,
  input  logic [AW-3:0]        i_next_addr,
  input  logic [CW-1:0]        i_a_sel,
  input  logic [CW-1:0]        i_b_sel,
  input  logic [NCOND-1:0]     i_cond_a,
  input  logic [NCOND-1:0]     i_cond_b,
  input  logic                 i_call,
  input  logic                 i_ret,
  input  logic                 i_restore,
  input  logic [NTRAP-1:0]     i_trap,
  input  logic                 i_jam,
  input  logic [AW-1:0]        i_jam_addr,
  output logic [AW-1:0]        o_roar,
  output logic [AW-1:0]        o_nextroar,
  output logic [HDEPTH*AW-1:0] o_hist,
  output logic [AW-1:0]        o_backup,
  output logic                 o_trap_taken,
  output logic                 o_stack_ovf,
  output logic                 o_stack_unf,
  output logic                 o_key_match
);

  localparam int PW = $clog2(SDEPTH + 1);
  localparam int TW = (NTRAP > 1) ? $clog2(NTRAP) : 1;
  localparam logic [PW-1:0] SP_FULL = PW'(SDEPTH);
  localparam logic [AW-1:0] ONE_AW  = AW'(1);

  logic [AW-1:0]    stack_r [SDEPTH];
  logic [AW-1:0]    hist_r  [HDEPTH];
  logic [PW-1:0]    sp_r;
  logic [NTRAP-1:0] pend_r;

  logic             a_bit_s;
  logic             b_bit_s;
  logic [AW-1:0]    normal_s;
  logic [TW-1:0]    trap_idx_s;
  logic [AW-1:0]    trap_vec_s;
  logic [NTRAP-1:0] pend_low_s;
  logic [NTRAP-1:0] pend_next_s;
  logic             take_s;
  logic             load_s;

  // Select 0 (and any select past NCOND) reads as constant 0.
  function automatic logic cond_bit(input logic [NCOND-1:0] v, input logic [CW-1:0] sel);
    logic r;
    r = 1'b0;
    for (int i = 1; i < NCOND; i++) begin
      r = r | ((sel == CW'(i)) & v[i]);
    end
    return r;
  endfunction

  // Next-address formation and trap arbitration
  always_comb begin
    a_bit_s    = cond_bit(i_cond_a, i_a_sel);
    b_bit_s    = cond_bit(i_cond_b, i_b_sel);
    normal_s   = {i_next_addr, a_bit_s, b_bit_s};
    trap_idx_s = '0;
    for (int k = NTRAP - 1; k >= 0; k--) begin
      trap_idx_s = pend_r[k] ? TW'(k) : trap_idx_s;
    end
    trap_vec_s  = TRAP_BASE + AW'({trap_idx_s, 2'b00});
    pend_low_s  = pend_r & (~pend_r + NTRAP'(1));
    take_s      = i_ros_advance & ~i_jam & (|pend_r);
    load_s      = i_jam | i_ros_advance;
    // A request arriving in the taking cycle must survive the clear of the lowest bit.
    if (take_s) begin
      pend_next_s = (pend_r & ~pend_low_s) | i_trap;
    end else begin
      pend_next_s = pend_r | i_trap;
    end
  end

  // Combinational outputs and history flattening
  always_comb begin
    o_nextroar  = normal_s;
    o_key_match = (i_jam_addr == o_roar);
    o_hist      = '0;
    for (int i = 0; i < HDEPTH; i++) begin
      o_hist[i*AW +: AW] = hist_r[i];
    end
  end

  // ROAR load, stack, trap and history state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_roar       <= '0;
      o_backup     <= '0;
      o_trap_taken <= 1'b0;
      o_stack_ovf  <= 1'b0;
      o_stack_unf  <= 1'b0;
      sp_r         <= '0;
      pend_r       <= '0;
      for (int i = 0; i < SDEPTH; i++) stack_r[i] <= '0;
      for (int i = 0; i < HDEPTH; i++) hist_r[i] <= '0;
    end else begin
      pend_r       <= pend_next_s;
      o_trap_taken <= take_s;
      if (load_s) begin
        for (int i = HDEPTH - 1; i > 0; i--) hist_r[i] <= hist_r[i-1];
        hist_r[0] <= o_roar;
      end
      if (i_jam) begin
        o_roar <= i_jam_addr;
      end else if (i_ros_advance) begin
        if (take_s) begin
          o_roar   <= trap_vec_s;
          o_backup <= normal_s;
        end else if (i_restore) begin
          o_roar <= o_backup;
        end else if (i_ret) begin
          if (sp_r == '0) begin
            o_roar      <= '0;
            o_stack_unf <= 1'b1;
          end else begin
            o_roar <= stack_r[0];
            for (int i = 0; i < SDEPTH - 1; i++) stack_r[i] <= stack_r[i+1];
            stack_r[SDEPTH-1] <= '0;
            sp_r <= sp_r - PW'(1);
          end
        end else if (i_call) begin
          // Stack is a shift register with the top at entry 0; a full push drops the oldest.
          o_roar <= normal_s;
          for (int i = SDEPTH - 1; i > 0; i--) stack_r[i] <= stack_r[i-1];
          stack_r[0] <= o_roar + ONE_AW;
          if (sp_r == SP_FULL) begin
            o_stack_ovf <= 1'b1;
          end else begin
            sp_r <= sp_r + PW'(1);
          end
        end else begin
          o_roar <= normal_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_x2050roseq.sv
// Directed self-checking bench for x2050roseq: addressing, call stack, traps, jam and history.
module tb_x2050roseq;

  logic         clk;
  logic         i_reset;
  logic         i_ros_advance;
  logic [10:0]  i_next_addr;
  logic [5:0]   i_a_sel;
  logic [5:0]   i_b_sel;
  logic [63:0]  i_cond_a;
  logic [63:0]  i_cond_b;
  logic         i_call;
  logic         i_ret;
  logic         i_restore;
  logic [3:0]   i_trap;
  logic         i_jam;
  logic [12:0]  i_jam_addr;
  logic [12:0]  o_roar;
  logic [12:0]  o_nextroar;
  logic [51:0]  o_hist;
  logic [12:0]  o_backup;
  logic         o_trap_taken;
  logic         o_stack_ovf;
  logic         o_stack_unf;
  logic         o_key_match;

  int compared;
  int mismatched;

  x2050roseq dut (
    .i_clk(clk), .i_reset(i_reset), .i_ros_advance(i_ros_advance),
    .i_next_addr(i_next_addr), .i_a_sel(i_a_sel), .i_b_sel(i_b_sel),
    .i_cond_a(i_cond_a), .i_cond_b(i_cond_b), .i_call(i_call), .i_ret(i_ret),
    .i_restore(i_restore), .i_trap(i_trap), .i_jam(i_jam), .i_jam_addr(i_jam_addr),
    .o_roar(o_roar), .o_nextroar(o_nextroar), .o_hist(o_hist), .o_backup(o_backup),
    .o_trap_taken(o_trap_taken), .o_stack_ovf(o_stack_ovf), .o_stack_unf(o_stack_unf),
    .o_key_match(o_key_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_ros_advance = 1'b0; i_next_addr = 11'h000; i_a_sel = 6'd0; i_b_sel = 6'd0;
    i_cond_a = 64'h0; i_cond_b = 64'h0; i_call = 1'b0; i_ret = 1'b0; i_restore = 1'b0;
    i_trap = 4'b0000; i_jam = 1'b0; i_jam_addr = 13'h0000;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (o_roar !== 13'h0000) begin mismatched++; $display("FAIL reset_roar: got %h want 0000", o_roar); end
    compared++; if (o_hist !== 52'h0) begin mismatched++; $display("FAIL reset_hist: got %h want 0", o_hist); end
    compared++; if (o_backup !== 13'h0000) begin mismatched++; $display("FAIL reset_backup: got %h want 0000", o_backup); end
    compared++; if ({o_trap_taken, o_stack_ovf, o_stack_unf} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b want 000", {o_trap_taken, o_stack_ovf, o_stack_unf}); end
    compared++; if (o_key_match !== 1'b1) begin mismatched++; $display("FAIL reset_key: got %b want 1", o_key_match); end
  endtask

  task automatic test_normal_addr();
    i_next_addr = 11'h2A5; i_a_sel = 6'd5; i_cond_a = 64'h21; i_b_sel = 6'd0; i_cond_b = ~64'h0;
    #1;
    compared++; if (o_nextroar !== 13'h0A96) begin mismatched++; $display("FAIL next_a5: got %h want 0A96", o_nextroar); end
    i_ros_advance = 1'b1;
    step();
    i_ros_advance = 1'b0;
    compared++; if (o_roar !== 13'h0A96) begin mismatched++; $display("FAIL adv_roar: got %h want 0A96", o_roar); end
    compared++; if (o_hist[12:0] !== 13'h0000) begin mismatched++; $display("FAIL adv_hist0: got %h want 0000", o_hist[12:0]); end
    i_next_addr = 11'h000; i_a_sel = 6'd0; i_cond_a = ~64'h0; i_b_sel = 6'd63; i_cond_b = 64'h8000_0000_0000_0000;
    #1;
    compared++; if (o_nextroar !== 13'h0001) begin mismatched++; $display("FAIL next_b63: got %h want 0001", o_nextroar); end
    i_a_sel = 6'd4; i_cond_a = 64'h20; i_b_sel = 6'd1; i_cond_b = 64'h1;
    #1;
    compared++; if (o_nextroar !== 13'h0000) begin mismatched++; $display("FAIL next_false: got %h want 0000", o_nextroar); end
    clear_inputs();
  endtask

  task automatic test_call_ret();
    do_reset();
    i_jam = 1'b1; i_jam_addr = 13'h0100;
    step();
    i_jam = 1'b0;
    compared++; if (o_roar !== 13'h0100) begin mismatched++; $display("FAIL jam_100: got %h want 0100", o_roar); end
    i_next_addr = 11'h080; i_call = 1'b1; i_ros_advance = 1'b1;
    step();
    compared++; if (o_roar !== 13'h0200) begin mismatched++; $display("FAIL call_roar: got %h want 0200", o_roar); end
    i_call = 1'b0; i_ret = 1'b1; i_next_addr = 11'h7FF;
    step();
    clear_inputs();
    compared++; if (o_roar !== 13'h0101) begin mismatched++; $display("FAIL ret_roar: got %h want 0101", o_roar); end
    compared++; if ({o_stack_ovf, o_stack_unf} !== 2'b00) begin mismatched++; $display("FAIL ret_flags: got %b want 00", {o_stack_ovf, o_stack_unf}); end
    compared++; if (o_hist[25:0] !== {13'h0100, 13'h0200}) begin mismatched++; $display("FAIL ret_hist: got %h want %h", o_hist[25:0], {13'h0100, 13'h0200}); end
  endtask

  task automatic test_stack_limits();
    logic [12:0] exp_ret [5];
    exp_ret = '{13'h0011, 13'h000D, 13'h0009, 13'h0005, 13'h0000};
    do_reset();
    i_call = 1'b1; i_ros_advance = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_next_addr = 11'(i + 1);
      step();
      compared++; if (o_roar !== 13'((i + 1) * 4)) begin mismatched++; $display("FAIL call%0d_roar: got %h want %h", i, o_roar, 13'((i + 1) * 4)); end
      compared++; if (o_stack_ovf !== (i == 4)) begin mismatched++; $display("FAIL call%0d_ovf: got %b want %b", i, o_stack_ovf, (i == 4)); end
    end
    // call stays asserted: ret must win and push nothing
    i_ret = 1'b1; i_next_addr = 11'h155;
    for (int i = 0; i < 5; i++) begin
      step();
      compared++; if (o_roar !== exp_ret[i]) begin mismatched++; $display("FAIL ret%0d_roar: got %h want %h", i, o_roar, exp_ret[i]); end
      compared++; if (o_stack_unf !== (i == 4)) begin mismatched++; $display("FAIL ret%0d_unf: got %b want %b", i, o_stack_unf, (i == 4)); end
    end
    clear_inputs();
    step();
    compared++; if ({o_stack_ovf, o_stack_unf} !== 2'b11) begin mismatched++; $display("FAIL flags_sticky: got %b want 11", {o_stack_ovf, o_stack_unf}); end
  endtask

  task automatic test_reset_mid();
    i_reset = 1'b1; i_jam = 1'b1; i_jam_addr = 13'h1234; i_ros_advance = 1'b1; i_call = 1'b1; i_trap = 4'b1111;
    step();
    i_reset = 1'b0;
    clear_inputs();
    compared++; if (o_roar !== 13'h0000) begin mismatched++; $display("FAIL rstmid_roar: got %h want 0000", o_roar); end
    compared++; if ({o_stack_ovf, o_stack_unf, o_trap_taken} !== 3'b000) begin mismatched++; $display("FAIL rstmid_flags: got %b want 000", {o_stack_ovf, o_stack_unf, o_trap_taken}); end
    i_ros_advance = 1'b1;
    step();
    i_ros_advance = 1'b0;
    compared++; if (o_trap_taken !== 1'b0) begin mismatched++; $display("FAIL rstmid_pend: got %b want 0", o_trap_taken); end
  endtask

  task automatic test_history();
    logic [12:0] vals [5];
    vals = '{13'h0111, 13'h0222, 13'h0333, 13'h0444, 13'h0555};
    do_reset();
    i_jam = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_jam_addr = vals[i];
      step();
    end
    clear_inputs();
    compared++; if (o_hist !== {13'h0111, 13'h0222, 13'h0333, 13'h0444}) begin mismatched++; $display("FAIL hist_full: got %h want %h", o_hist, {13'h0111, 13'h0222, 13'h0333, 13'h0444}); end
    step();
    compared++; if (o_hist !== {13'h0111, 13'h0222, 13'h0333, 13'h0444}) begin mismatched++; $display("FAIL hist_hold: got %h want %h", o_hist, {13'h0111, 13'h0222, 13'h0333, 13'h0444}); end
    compared++; if (o_roar !== 13'h0555) begin mismatched++; $display("FAIL hist_roar: got %h want 0555", o_roar); end
  endtask

  task automatic test_trap();
    do_reset();
    i_next_addr = 11'h0CC; i_a_sel = 6'd1; i_cond_a = 64'h2; i_b_sel = 6'd2; i_cond_b = 64'h4;
    i_trap = 4'b0110;
    step();
    i_trap = 4'b0000;
    compared++; if (o_nextroar !== 13'h0333) begin mismatched++; $display("FAIL trap_next: got %h want 0333", o_nextroar); end
    compared++; if ({o_roar, o_trap_taken} !== {13'h0000, 1'b0}) begin mismatched++; $display("FAIL trap_noadv: got %h/%b want 0000/0", o_roar, o_trap_taken); end
    i_ros_advance = 1'b1; i_ret = 1'b1;
    step();
    i_ret = 1'b0;
    compared++; if (o_roar !== 13'h0044) begin mismatched++; $display("FAIL trap1_roar: got %h want 0044", o_roar); end
    compared++; if (o_backup !== 13'h0333) begin mismatched++; $display("FAIL trap1_backup: got %h want 0333", o_backup); end
    compared++; if ({o_trap_taken, o_stack_unf} !== 2'b10) begin mismatched++; $display("FAIL trap1_taken_unf: got %b want 10", {o_trap_taken, o_stack_unf}); end
    step();
    compared++; if ({o_roar, o_trap_taken} !== {13'h0048, 1'b1}) begin mismatched++; $display("FAIL trap2: got %h/%b want 0048/1", o_roar, o_trap_taken); end
    i_restore = 1'b1;
    step();
    clear_inputs();
    compared++; if ({o_roar, o_trap_taken} !== {13'h0333, 1'b0}) begin mismatched++; $display("FAIL restore: got %h/%b want 0333/0", o_roar, o_trap_taken); end
  endtask

  task automatic test_jam();
    do_reset();
    i_trap = 4'b0001;
    step();
    i_trap = 4'b0000; i_jam = 1'b1; i_jam_addr = 13'h1FFF;
    step();
    compared++; if ({o_roar, o_key_match, o_trap_taken} !== {13'h1FFF, 1'b1, 1'b0}) begin mismatched++; $display("FAIL jam_1fff: got %h/%b/%b want 1fff/1/0", o_roar, o_key_match, o_trap_taken); end
    i_jam_addr = 13'h0ABC; i_ros_advance = 1'b1;
    #1;
    compared++; if (o_key_match !== 1'b0) begin mismatched++; $display("FAIL key_nomatch: got %b want 0", o_key_match); end
    step();
    compared++; if ({o_roar, o_trap_taken, o_backup} !== {13'h0ABC, 1'b0, 13'h0000}) begin mismatched++; $display("FAIL jam_adv: got %h/%b/%h want 0abc/0/0000", o_roar, o_trap_taken, o_backup); end
    i_jam = 1'b0;
    step();
    i_ros_advance = 1'b0;
    compared++; if ({o_roar, o_trap_taken} !== {13'h0040, 1'b1}) begin mismatched++; $display("FAIL jam_pend: got %h/%b want 0040/1", o_roar, o_trap_taken); end
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    i_next_addr = 11'h048; i_trap = 4'b1000; i_ros_advance = 1'b1;
    step();
    i_trap = 4'b0000;
    compared++; if ({o_roar, o_trap_taken} !== {13'h0120, 1'b0}) begin mismatched++; $display("FAIL same_cycle: got %h/%b want 0120/0", o_roar, o_trap_taken); end
    step();
    clear_inputs();
    compared++; if ({o_roar, o_trap_taken, o_backup} !== {13'h004C, 1'b1, 13'h0120}) begin mismatched++; $display("FAIL next_take: got %h/%b/%h want 004c/1/0120", o_roar, o_trap_taken, o_backup); end
    step();
    compared++; if (o_trap_taken !== 1'b0) begin mismatched++; $display("FAIL taken_pulse: got %b want 0", o_trap_taken); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    compared = 0;
    mismatched = 0;
    i_reset = 1'b1;
    clear_inputs();
    test_reset();
    test_normal_addr();
    test_call_ret();
    test_stack_limits();
    test_reset_mid();
    test_history();
    test_trap();
    test_jam();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
